frag_scan_iterator: RTL

- Parametrised successor to the single-pixel fragment iterator: walks a triangle's screen-space bounding box in integer pixel coordinates.
- Emits LANES horizontally adjacent fragments per beat, each beat with a per-lane valid mask.
- Sits between triangle setup (bounding box producer) and the per-fragment edge-test stage.
- Clips the box to the screen and applies full upstream/downstream handshaking with backpressure.

---
 rtl/frag_scan_iterator.sv | 135 +++++++++++++
 1 files changed

// File: rtl/frag_scan_iterator.sv
// frag_scan_iterator: walks a screen-clipped bounding box emitting LANES adjacent fragments per beat.
// Define FRAG_SERPENTINE_EN for serpentine row order; the default build scans in raster order.
module frag_scan_iterator #(
  parameter int COORD_W  = 10,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int LANES    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               nd,
  output logic               us_rfd,
  input  logic [COORD_W-1:0] min_x,
  input  logic [COORD_W-1:0] max_x,
  input  logic [COORD_W-1:0] min_y,
  input  logic [COORD_W-1:0] max_y,
  input  logic               ds_rfd,
  output logic               rdy,
  output logic [COORD_W-1:0] frag_x,
  output logic [COORD_W-1:0] frag_y,
  output logic [LANES-1:0]   lane_mask,
  output logic               last,
  output logic               box_done
);
  localparam logic [COORD_W-1:0] XM = COORD_W'(SCREEN_W - 1);
  localparam logic [COORD_W-1:0] YM = COORD_W'(SCREEN_H - 1);
  localparam logic [COORD_W-1:0] STEP = COORD_W'(LANES);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state_q, state_d;
  logic live_q;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0] min_x_q, min_x_d, max_x_q, max_x_d, min_y_q, min_y_d, max_y_q, max_y_d;
  logic [COORD_W-1:0] cmx, cmy;
  logic accept, xfer, row_end;
`ifdef FRAG_SERPENTINE_EN
  logic [COORD_W-1:0] xr_q, xr_d, span;
  logic odd_q, odd_d;
`endif
  assign rdy      = state_q == SCAN;
  assign us_rfd   = (state_q == IDLE) & live_q;
  assign box_done = state_q == DONE;
  assign frag_x   = x_q;
  assign frag_y   = y_q;
  always_comb begin
    cmx    = max_x > XM ? XM : max_x;
    cmy    = max_y > YM ? YM : max_y;
    accept = nd & us_rfd;
    xfer   = rdy & ds_rfd;
    for (int i = 0; i < LANES; i++)
      lane_mask[i] = rdy & (({1'b0, x_q} + (COORD_W+1)'(i)) <= {1'b0, max_x_q});
`ifdef FRAG_SERPENTINE_EN
    span    = cmx - min_x;
    row_end = odd_q ? (x_q == min_x_q) : (x_q == xr_q);
`else
    row_end = ({1'b0, x_q} + (COORD_W+1)'(LANES)) > {1'b0, max_x_q};
`endif
    last = rdy & row_end & (y_q == max_y_q);
  end
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    min_x_d = min_x_q;
    max_x_d = max_x_q;
    min_y_d = min_y_q;
    max_y_d = max_y_q;
`ifdef FRAG_SERPENTINE_EN
    xr_d  = xr_q;
    odd_d = odd_q;
`endif
    if (accept) begin
      min_x_d = min_x;
      max_x_d = cmx;
      min_y_d = min_y;
      max_y_d = cmy;
      x_d = min_x;
      y_d = min_y;
      state_d = (min_x > cmx || min_y > cmy) ? DONE : SCAN;
`ifdef FRAG_SERPENTINE_EN
      // Start of odd rows: the last whole-group origin, (G-1)*LANES past min_x
      xr_d  = min_x + ((span >> $clog2(LANES)) << $clog2(LANES));
      odd_d = 1'b0;
`endif
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else if (xfer) begin
      if (last) begin
        state_d = DONE;
      end else if (row_end) begin
        y_d = y_q + 1'b1;
`ifdef FRAG_SERPENTINE_EN
        x_d   = odd_q ? min_x_q : xr_q;
        odd_d = ~odd_q;
`else
        x_d = min_x_q;
`endif
      end else begin
`ifdef FRAG_SERPENTINE_EN
        x_d = odd_q ? x_q - STEP : x_q + STEP;
`else
        x_d = x_q + STEP;
`endif
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      live_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      min_x_q <= '0;
      max_x_q <= '0;
      min_y_q <= '0;
      max_y_q <= '0;
`ifdef FRAG_SERPENTINE_EN
      xr_q  <= '0;
      odd_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      x_q     <= x_d;
      y_q     <= y_d;
      min_x_q <= min_x_d;
      max_x_q <= max_x_d;
      min_y_q <= min_y_d;
      max_y_q <= max_y_d;
`ifdef FRAG_SERPENTINE_EN
      xr_q  <= xr_d;
      odd_q <= odd_d;
`endif
    end
  end
endmodule
